// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (8N1 by default). Valid/ready input with a 1-deep holding register.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits; PARITY_ODD selects odd parity.
module uart_tx #(
  parameter int DATA_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT),
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_valid,
  input  logic [DATA_LENGTH-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int IDX_WIDTH = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DATA_LENGTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (CNT_WIDTH < $clog2(CLKS_PER_BIT)) begin : g_bad_cnt_width
    $error("uart_tx: CNT_WIDTH too narrow for CLKS_PER_BIT");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic [DATA_LENGTH-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
  logic                   load;
  logic                   done;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = 1'b1;
    load        = 1'b0;
    done        = 1'b0;
    bit_end     = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Accept only into an empty holding register; loads only drain a full one, so they never collide.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done = 1'b1;
          if (hold_full_q) load = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
`endif
    end

    // Bit timer restarts at every bit boundary and on every state change, including STOP->START.
    if (state_q == ST_IDLE || state_d != state_q || load || bit_end) cnt_d = '0;
    else                                                            cnt_d = cnt_q + CNT_WIDTH'(1);

    // The line is registered, so drive it from the state being entered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: the holding register is cleared by reset too, so a word queued before reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = done;

endmodule
